// File: rtl/gate_chk_pkg.sv
// Shared types and the golden AND-gate function used by the response checker.
// exp_out packs the expected DUT outputs as {g,f,e}.
package gate_chk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [15:0] COV_FULL = 16'hFFFF;

  function automatic logic [2:0] exp_out(input logic [3:0] vec);
    return {&vec, vec[3] & vec[2], vec[1] & vec[0]};
  endfunction

endpackage

// File: rtl/and4_ref_model.sv
// Combinational golden model of the 4-input AND lab DUT.
// vec is {d,c,b,a}; exp is {g,f,e}.
module and4_ref_model
  import gate_chk_pkg::*;
(
  input  logic [3:0] vec,
  output logic [2:0] exp
);

  assign exp = exp_out(vec);

endmodule

// File: rtl/and_gate_response_checker.sv
// Response checker for the 4-input AND lab: accepts a vector, waits SETTLE_CYC edges,
// samples the DUT, compares against the golden model and tracks errors and coverage.
module and_gate_response_checker
  import gate_chk_pkg::*;
#(
  parameter int SETTLE_CYC = 2,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             vec_valid,
  input  logic [3:0]       vec,
  output logic             vec_ready,
  input  logic             dut_e,
  input  logic             dut_f,
  input  logic             dut_g,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [15:0]      cov_mask,
  output logic [3:0]       first_err_vec,
  output logic             first_err_valid
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);

  state_t           state_reg, state_next;
  logic [3:0]       cnt_reg, cnt_next;
  logic [3:0]       vec_q_reg, vec_q_next;
  logic [ERR_W-1:0] err_reg, err_next;
  logic [15:0]      cov_reg, cov_next;
  logic [3:0]       first_vec_reg, first_vec_next;
  logic             first_valid_reg, first_valid_next;

  logic [2:0] exp;
  logic       mismatch;

  and4_ref_model u_ref (
    .vec (vec_q_reg),
    .exp (exp)
  );

  // Case inequality so X/Z on the DUT outputs is reported as a mismatch in simulation.
  assign mismatch = ({dut_g, dut_f, dut_e} !== exp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      vec_q_reg       <= '0;
      err_reg         <= '0;
      cov_reg         <= '0;
      first_vec_reg   <= '0;
      first_valid_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      vec_q_reg       <= vec_q_next;
      err_reg         <= err_next;
      cov_reg         <= cov_next;
      first_vec_reg   <= first_vec_next;
      first_valid_reg <= first_valid_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    vec_q_next       = vec_q_reg;
    err_next         = err_reg;
    cov_next         = cov_reg;
    first_vec_next   = first_vec_reg;
    first_valid_next = first_valid_reg;

    // start wins over everything, including a sample that would land on this edge.
    if (start) begin
      err_next         = '0;
      cov_next         = '0;
      first_vec_next   = '0;
      first_valid_next = 1'b0;
      state_next       = ARMED;
    end else begin
      case (state_reg)
        IDLE: ;
        ARMED: begin
          if (vec_valid) begin
            vec_q_next = vec;
            cnt_next   = SETTLE_LOAD;
            state_next = SETTLE;
          end
        end
        SETTLE: begin
          if (cnt_reg == 4'd0) begin
            if (mismatch) begin
              if (err_reg != {ERR_W{1'b1}}) err_next = err_reg + ERR_W'(1);
              if (!first_valid_reg) begin
                first_vec_next   = vec_q_reg;
                first_valid_next = 1'b1;
              end
            end
            cov_next   = cov_reg | (16'd1 << vec_q_reg);
            state_next = (cov_next == COV_FULL) ? DONE : ARMED;
          end else begin
            cnt_next = cnt_reg - 4'd1;
          end
        end
        DONE: ;
        default: state_next = IDLE;
      endcase
    end
  end

  assign vec_ready       = (state_reg == ARMED);
  assign busy            = (state_reg == ARMED) || (state_reg == SETTLE);
  assign done            = (state_reg == DONE);
  assign pass            = done && (err_reg == '0);
  assign err_count       = err_reg;
  assign cov_mask        = cov_reg;
  assign first_err_vec   = first_vec_reg;
  assign first_err_valid = first_valid_reg;

endmodule

// File: tb/tb_and_gate_response_checker.sv
// Scoreboard bench: a driver pushes expected checker state per accepted vector and a
// monitor pops and compares each time the checker finishes a sample.
module tb_and_gate_response_checker;

  localparam int SETTLE = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        vec_valid = 1'b0;
  logic [3:0]  vec = 4'd0;
  logic        dut_e, dut_f, dut_g;

  logic        vec_ready, busy, done, pass, first_err_valid;
  logic [7:0]  err_count;
  logic [15:0] cov_mask;
  logic [3:0]  first_err_vec;

  logic        vec_ready_s, busy_s, done_s, pass_s, first_err_valid_s;
  logic [1:0]  err_count_s;
  logic [15:0] cov_mask_s;
  logic [3:0]  first_err_vec_s;

  always #5 clk = ~clk;

  and_gate_response_checker #(.SETTLE_CYC(SETTLE), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_valid(vec_valid), .vec(vec),
    .vec_ready(vec_ready), .dut_e(dut_e), .dut_f(dut_f), .dut_g(dut_g),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count), .cov_mask(cov_mask),
    .first_err_vec(first_err_vec), .first_err_valid(first_err_valid)
  );

  and_gate_response_checker #(.SETTLE_CYC(SETTLE), .ERR_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_valid(vec_valid), .vec(vec),
    .vec_ready(vec_ready_s), .dut_e(dut_e), .dut_f(dut_f), .dut_g(dut_g),
    .busy(busy_s), .done(done_s), .pass(pass_s), .err_count(err_count_s), .cov_mask(cov_mask_s),
    .first_err_vec(first_err_vec_s), .first_err_valid(first_err_valid_s)
  );

  int n_vec = 0;
  int n_bad = 0;
  int n_chk = 0;
  int fault_mode = 0;   // 0 good gate, 1 g stuck-at-0, 2 e inverted
  logic [3:0] applied = 4'd0;

  // Gate under test: holds the last vector the checker accepted.
  always @(posedge clk) if (vec_valid && vec_ready) applied <= vec;

  function automatic logic [2:0] ideal(input int v);
    logic e, f, g;
    e = (v % 4) == 3;
    f = (v / 4) == 3;
    g = (v == 15);
    return {g, f, e};
  endfunction

  function automatic logic [2:0] resp_of(input int v, input int mode);
    logic [2:0] r;
    r = ideal(v);
    if (mode == 1) r[2] = 1'b0;
    if (mode == 2) r[0] = ~r[0];
    return r;
  endfunction

  assign {dut_g, dut_f, dut_e} = resp_of(int'(applied), fault_mode);

  function automatic int sat(input int x, input int m);
    return (x > m) ? m : x;
  endfunction

  typedef struct {
    int          err8;
    int          err2;
    logic [15:0] cov;
    logic [3:0]  fvec;
    logic        fvalid;
    logic        dn;
  } exp_t;

  exp_t        q[$];
  int          m_err;
  logic [15:0] m_cov;
  logic [3:0]  m_fvec;
  logic        m_fvalid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_clear();
    m_err = 0; m_cov = '0; m_fvec = '0; m_fvalid = 1'b0;
    q.delete();
  endtask

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic send(input int v);
    int w;
    exp_t e;
    w = 0;
    vec = v[3:0];
    vec_valid = 1'b1;
    while (!vec_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!vec_ready) begin
      check("handshake_timeout", 32'd1, 32'd0);
      vec_valid = 1'b0;
      return;
    end
    if (resp_of(v, fault_mode) != ideal(v)) begin
      m_err++;
      if (!m_fvalid) begin
        m_fvalid = 1'b1;
        m_fvec = v[3:0];
      end
    end
    m_cov[v] = 1'b1;
    e.err8 = sat(m_err, 255);
    e.err2 = sat(m_err, 3);
    e.cov = m_cov;
    e.fvec = m_fvec;
    e.fvalid = m_fvalid;
    e.dn = (m_cov == 16'hFFFF);
    q.push_back(e);
    n_vec++;
    @(negedge clk);
    vec_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (q.size() != 0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (q.size() != 0) check("drain_timeout", q.size(), 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    model_clear();
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_vec_ready"}, vec_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_err_count"}, err_count, 0);
    check({tag, "_cov_mask"}, cov_mask, 0);
    check({tag, "_first_err_vec"}, first_err_vec, 0);
    check({tag, "_first_err_valid"}, first_err_valid, 0);
    check({tag, "_err_count_w2"}, err_count_s, 0);
  endtask

  // Monitor: a sample has completed when vec_ready or done rises.
  initial begin
    logic prev_rdy, prev_done;
    int low;
    exp_t e;
    prev_rdy = 1'b0; prev_done = 1'b0; low = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_rdy = 1'b0; prev_done = 1'b0; low = 0;
      end else begin
        if (prev_rdy && !vec_ready) low = 0;
        if (!vec_ready && busy) low++;
        if (((vec_ready && !prev_rdy) || (done && !prev_done)) && q.size() > 0) begin
          e = q.pop_front();
          check("settle_cycles", low, SETTLE);
          check("err_count", err_count, e.err8);
          check("err_count_w2", err_count_s, e.err2);
          check("cov_mask", cov_mask, e.cov);
          check("first_err_vec", first_err_vec, e.fvec);
          check("first_err_valid", first_err_valid, e.fvalid);
          check("done", done, e.dn);
          check("pass", pass, e.dn && (e.err8 == 0));
          check("busy", busy, !e.dn);
        end
        prev_rdy = vec_ready;
        prev_done = done;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    model_clear();

    // Reset and arming
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_vec_ready", vec_ready, 0);
    do_start();
    check("armed_vec_ready", vec_ready, 1);
    $display("reset/start: vec_ready=%0b", vec_ready);

    // Golden sweep
    fault_mode = 0;
    for (int v = 0; v < 16; v++) send(v);
    drain();
    check("golden_done", done, 1);
    check("golden_pass", pass, 1);
    check("golden_cov", cov_mask, 16'hFFFF);
    $display("golden sweep: done=%0b pass=%0b err=%0d cov=%h", done, pass, err_count, cov_mask);

    // g stuck-at-0
    do_start();
    fault_mode = 1;
    for (int v = 0; v < 16; v++) send(v);
    drain();
    check("g_sa0_err", err_count, 1);
    check("g_sa0_first", first_err_vec, 4'hF);
    check("g_sa0_pass", pass, 0);
    $display("g stuck-0: err=%0d first=%h pass=%0b", err_count, first_err_vec, pass);

    // e inverted: 2-bit counter saturates
    do_start();
    fault_mode = 2;
    for (int v = 0; v < 16; v++) send(v);
    drain();
    check("e_inv_err_w2", err_count_s, 3);
    check("e_inv_err_w8", err_count, 16);
    check("e_inv_first", first_err_vec, 4'h0);
    $display("e inverted: err8=%0d err2=%0d first=%h", err_count, err_count_s, first_err_vec);

    // 8-bit saturation with random vectors that never complete coverage
    do_start();
    fault_mode = 2;
    for (int i = 0; i < 260; i++) send(int'($urandom_range(14, 0)));
    drain();
    check("sat8_err", err_count, 255);
    check("sat8_busy", busy, 1);
    send(15);
    drain();
    check("sat8_done", done, 1);
    $display("saturation: err8=%0d done=%0b", err_count, done);

    // Random vectors under a random fault until coverage completes
    do_start();
    fault_mode = int'($urandom_range(2, 0));
    guard = 0;
    while (m_cov != 16'hFFFF && guard < 400) begin
      send(int'($urandom_range(15, 0)));
      guard++;
    end
    drain();
    check("random_done", done, 1);
    $display("random run: fault=%0d vectors=%0d err=%0d", fault_mode, guard, err_count);

    // Repeats: 15 never applied
    do_start();
    fault_mode = 0;
    repeat (3) send(5);
    for (int v = 0; v < 15; v++) send(v);
    drain();
    check("repeat_cov", cov_mask, 16'h7FFF);
    check("repeat_busy", busy, 1);
    check("repeat_done", done, 0);
    $display("repeats: cov=%h busy=%0b done=%0b", cov_mask, busy, done);

    // start during SETTLE discards the in-flight compare
    do_start();
    fault_mode = 2;
    send(1); send(2);
    drain();
    send(3);
    check("pre_start_busy", busy, 1);
    check("pre_start_ready", vec_ready, 0);
    do_start();
    check("int_start_ready", vec_ready, 1);
    check("int_start_err", err_count, 0);
    check("int_start_cov", cov_mask, 0);
    check("int_start_fvalid", first_err_valid, 0);
    repeat (3) @(negedge clk);
    check("int_start_no_compare", err_count, 0);
    $display("start mid-settle: ready=%0b err=%0d cov=%h", vec_ready, err_count, cov_mask);

    // Async reset mid-SETTLE
    send(4); send(6);
    drain();
    send(7);
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    check_all_zero("async_reset");
    $display("reset mid-settle: busy=%0b err=%0d cov=%h", busy, err_count, cov_mask);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
